// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE cluster and its skew feeder.
// Imported by the feeder, its lane buffers and the cluster top.
package pe_pkg;

    localparam int LANES_DEF  = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN
    } feeder_state_e;

    // Ceiling log2, never below 1 so it can size a port.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/skew_lane_buf.sv
// One lane's activation/weight register file.
// Single write port, asynchronous read port, contents not reset.
module skew_lane_buf #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_act,
    input  logic [DATA_W-1:0] wr_wgt,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_act,
    output logic [DATA_W-1:0] rd_wgt
);

    logic [DATA_W-1:0] mem_act [DEPTH];
    logic [DATA_W-1:0] mem_wgt [DEPTH];

    // Store one entry; a later write to the same entry overwrites it.
    always_ff @(posedge clk) begin
        if (we && (32'(wr_idx) < DEPTH)) begin
            mem_act[wr_idx] <= wr_act;
            mem_wgt[wr_idx] <= wr_wgt;
        end
    end

    assign rd_act = (32'(rd_idx) < DEPTH) ? mem_act[rd_idx] : '0;
    assign rd_wgt = (32'(rd_idx) < DEPTH) ? mem_wgt[rd_idx] : '0;

endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers per-lane act/wgt vectors and streams them into the PE
// array with a one-cycle-per-lane diagonal skew, then awaits array done.
module systolic_skew_feeder
    import pe_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024,
    localparam int LANE_W = clog2(LANES),
    localparam int IDX_W  = clog2(DEPTH),
    localparam int CNT_W  = clog2(LANES + DEPTH + 1),
    localparam int LEN_W  = clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [LANE_W-1:0]       load_lane,
    input  logic [IDX_W-1:0]        load_idx,
    input  logic [DATA_W-1:0]       load_act,
    input  logic [DATA_W-1:0]       load_wgt,
    input  logic [LEN_W-1:0]        k_len,
    input  logic                    start,
    output logic                    busy,
    output logic [LANES*DATA_W-1:0] activations,
    output logic [LANES*DATA_W-1:0] weights,
    output logic [LANES-1:0]        lane_done,
    input  logic [LANES-1:0]        array_done_in,
    output logic                    done,
    output logic                    err
);

    localparam int TMO_W = clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    feeder_state_e state;

    logic [CNT_W-1:0]        t_q;
    logic [TMO_W-1:0]        tmo_q;
    logic [LEN_W-1:0]        k_q;
    logic [LANES*DATA_W-1:0] act_q;
    logic [LANES*DATA_W-1:0] wgt_q;
    logic [LANES*DATA_W-1:0] feed_act;
    logic [LANES*DATA_W-1:0] feed_wgt;
    logic [LANES-1:0]        lane_done_q;
    logic [LANES-1:0]        done_hit;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic [CNT_W-1:0]        k_ext;
    logic [CNT_W-1:0]        t_last;
    logic                    k_ok;
    logic                    wr_en;
    logic                    unused_array_done;

    assign load_ready  = (state == ST_IDLE);
    assign wr_en       = en && load_valid && load_ready;
    assign k_ok        = (k_len != '0) && (32'(k_len) <= DEPTH);
    assign k_ext       = CNT_W'(k_q);
    assign t_last      = CNT_W'(LANES - 1) + k_ext;

    // Only the last lane's done ends a pass.
    assign unused_array_done = ^array_done_in;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [CNT_W-1:0] LI = CNT_W'(i);

        logic [CNT_W-1:0]  rel;
        logic              in_win;
        logic [DATA_W-1:0] rd_act;
        logic [DATA_W-1:0] rd_wgt;

        // rel is only used when t >= i, so it never wraps in use.
        assign rel         = t_q - LI;
        assign in_win      = (t_q >= LI) && (rel < k_ext);
        assign done_hit[i] = (t_q == LI + k_ext);

        skew_lane_buf #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W)
        ) u_buf (
            .clk    (clk),
            .we     (wr_en && (load_lane == LANE_W'(i))),
            .wr_idx (load_idx),
            .wr_act (load_act),
            .wr_wgt (load_wgt),
            .rd_idx (rel[IDX_W-1:0]),
            .rd_act (rd_act),
            .rd_wgt (rd_wgt)
        );

        assign feed_act[i*DATA_W +: DATA_W] = in_win ? rd_act : '0;
        assign feed_wgt[i*DATA_W +: DATA_W] = in_win ? rd_wgt : '0;
    end

    // Pass sequencer: IDLE accepts loads/start, FEED skews, DRAIN waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            t_q         <= '0;
            tmo_q       <= '0;
            k_q         <= '0;
            act_q       <= '0;
            wgt_q       <= '0;
            lane_done_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (en) begin
            unique case (state)
                ST_IDLE: begin
                    act_q       <= '0;
                    wgt_q       <= '0;
                    lane_done_q <= '0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    if (start) begin
                        if (k_ok) begin
                            k_q   <= k_len;
                            t_q   <= '0;
                            state <= ST_FEED;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_FEED: begin
                    busy_q      <= 1'b1;
                    act_q       <= feed_act;
                    wgt_q       <= feed_wgt;
                    lane_done_q <= lane_done_q | done_hit;
                    if (t_q == t_last) begin
                        tmo_q <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        t_q <= t_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    act_q <= '0;
                    wgt_q <= '0;
                    if (array_done_in[LANES-1]) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign activations = act_q;
    assign weights     = wgt_q;
    assign lane_done   = lane_done_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Testbench for systolic_skew_feeder: behavioural pass model compared
// every cycle, plus hand-computed literal checks on fixed passes.
module tb_systolic_skew_feeder;

    localparam int L  = 8;
    localparam int DW = 16;
    localparam int D  = 16;
    localparam int TO = 64;
    localparam int LW = 3;
    localparam int IW = 4;
    localparam int KW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          load_valid = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] load_lane = '0;
    logic [IW-1:0] load_idx = '0;
    logic [DW-1:0] load_act = '0;
    logic [DW-1:0] load_wgt = '0;
    logic [KW-1:0] k_len = '0;
    logic [L-1:0]  array_done_in = '0;

    logic            load_ready;
    logic            busy;
    logic            done;
    logic            err;
    logic [L*DW-1:0] activations;
    logic [L*DW-1:0] weights;
    logic [L-1:0]    lane_done;

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .LANES   (L),
        .DATA_W  (DW),
        .DEPTH   (D),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_lane     (load_lane),
        .load_idx      (load_idx),
        .load_act      (load_act),
        .load_wgt      (load_wgt),
        .k_len         (k_len),
        .start         (start),
        .busy          (busy),
        .activations   (activations),
        .weights       (weights),
        .lane_done     (lane_done),
        .array_done_in (array_done_in),
        .done          (done),
        .err           (err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Behavioural model: phase 0 idle, 1 feeding, 2 draining.
    logic [DW-1:0] mact [L][D];
    logic [DW-1:0] mwgt [L][D];
    int            ph = 0;
    int            mk = 0;
    int            mc = 0;
    int            md = 0;
    logic [DW-1:0] e_act [L];
    logic [DW-1:0] e_wgt [L];
    logic [L-1:0]  e_ld = '0;
    logic          e_busy = 1'b0;
    logic          e_done = 1'b0;
    logic          e_err = 1'b0;

    task automatic check(input string nm, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] lane_val(input logic [L*DW-1:0] v,
                                               input int i);
        return v[i*DW +: DW];
    endfunction

    task automatic zero_lanes();
        for (int i = 0; i < L; i++) begin
            e_act[i] = '0;
            e_wgt[i] = '0;
        end
    endtask

    task automatic model_reset();
        ph = 0;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_err = 1'b0;
        e_ld = '0;
        zero_lanes();
    endtask

    // Lane i element j appears j+i+1 cycles after the start edge.
    task automatic model_step();
        if (ph == 0) begin
            e_done = 1'b0;
            e_err = 1'b0;
            e_busy = 1'b0;
            e_ld = '0;
            zero_lanes();
            if (load_valid) begin
                mact[load_lane][load_idx] = load_act;
                mwgt[load_lane][load_idx] = load_wgt;
            end
            if (start) begin
                if (k_len >= 1 && k_len <= D) begin
                    ph = 1;
                    mk = int'(k_len);
                    mc = 0;
                end else begin
                    e_err = 1'b1;
                end
            end
        end else if (ph == 1) begin
            mc++;
            e_busy = 1'b1;
            for (int i = 0; i < L; i++) begin
                int j;
                j = mc - 1 - i;
                if (j >= 0 && j < mk) begin
                    e_act[i] = mact[i][j];
                    e_wgt[i] = mwgt[i][j];
                end else begin
                    e_act[i] = '0;
                    e_wgt[i] = '0;
                end
                e_ld[i] = (mc >= i + mk + 1);
            end
            if (mc == L + mk) begin
                ph = 2;
                md = 0;
            end
        end else begin
            md++;
            zero_lanes();
            if (array_done_in[L-1]) begin
                e_done = 1'b1;
                e_busy = 1'b0;
                ph = 0;
            end else if (md == TO) begin
                e_done = 1'b1;
                e_err = 1'b1;
                e_busy = 1'b0;
                ph = 0;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else if (en) model_step();
        end
    end

    task automatic compare_all();
        logic [L*DW-1:0] fa;
        logic [L*DW-1:0] fw;
        for (int i = 0; i < L; i++) begin
            fa[i*DW +: DW] = e_act[i];
            fw[i*DW +: DW] = e_wgt[i];
        end
        check("activations", 128'(activations), 128'(fa));
        check("weights", 128'(weights), 128'(fw));
        check("lane_done", 128'(lane_done), 128'(e_ld));
        check("busy", 128'(busy), 128'(e_busy));
        check("done", 128'(done), 128'(e_done));
        check("err", 128'(err), 128'(e_err));
        check("load_ready", 128'(load_ready), 128'(ph == 0));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) compare_all();
        end
    end

    task automatic load(input int lane, input int idx, input int a, input int w);
        load_valid = 1'b1;
        load_lane = LW'(lane);
        load_idx = IW'(idx);
        load_act = DW'(a);
        load_wgt = DW'(w);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic load_scn1();
        for (int i = 0; i < L; i++)
            for (int j = 0; j < 4; j++)
                load(i, j, i * 4 + j + 1, 'h100 + i * 4 + j);
    endtask

    // K=4 pass on the fixed data; returns in cycle 12 (DRAIN entry).
    task automatic run_scn1();
        k_len = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c <= 4)
                check("s1_lane0_act", 128'(lane_val(activations, 0)), 128'(c));
            if (c >= 8 && c <= 11) begin
                check("s1_lane7_act", 128'(lane_val(activations, 7)), 128'(29 + c - 8));
                check("s1_lane7_wgt", 128'(lane_val(weights, 7)), 128'('h11C + c - 8));
            end
            if (c == 4) check("s1_ld0_early", 128'(lane_done[0]), 128'(0));
            if (c == 5) check("s1_ld0", 128'(lane_done[0]), 128'(1));
            if (c == 11) check("s1_ld7_early", 128'(lane_done[7]), 128'(0));
            if (c == 12) check("s1_ld7", 128'(lane_done[7]), 128'(1));
        end
    endtask

    task automatic finish_done(input int wait_n);
        repeat (wait_n) @(negedge clk);
        array_done_in = 8'h80;
        @(negedge clk);
        check("s2_done", 128'(done), 128'(1));
        check("s2_busy", 128'(busy), 128'(0));
        check("s2_ld_held", 128'(lane_done), 128'(8'hFF));
        array_done_in = '0;
        @(negedge clk);
        check("s2_ld_clear", 128'(lane_done), 128'(0));
        check("s2_done_end", 128'(done), 128'(0));
    endtask

    initial begin
        bit ended;
        int kr;
        en = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_on = 1'b1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_ready", 128'(load_ready), 128'(1));
        check("rst_act", 128'(activations), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed pass, then array done 20 cycles into DRAIN.
        load_scn1();
        run_scn1();
        finish_done(20);

        // Timeout pass: done and err together at DRAIN cycle 64.
        k_len = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (75) @(negedge clk);
        check("s3_done_early", 128'(done), 128'(0));
        @(negedge clk);
        check("s3_done", 128'(done), 128'(1));
        check("s3_err", 128'(err), 128'(1));
        @(negedge clk);
        check("s3_done_end", 128'(done), 128'(0));
        check("s3_ready", 128'(load_ready), 128'(1));

        // Rejected starts.
        for (int n = 0; n < 2; n++) begin
            k_len = (n == 0) ? KW'(0) : KW'(17);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("s4_err", 128'(err), 128'(1));
            check("s4_busy", 128'(busy), 128'(0));
            @(negedge clk);
            check("s4_err_end", 128'(err), 128'(0));
            check("s4_act", 128'(activations), 128'(0));
        end

        // Enable drop mid-FEED with stray start/load during the pass.
        k_len = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b0;
        start = 1'b1;
        k_len = 2;
        load_valid = 1'b1;
        load_lane = 2;
        load_idx = 3;
        load_act = 16'hDEAD;
        load_wgt = 16'hBEEF;
        repeat (3) @(negedge clk);
        check("s5_hold_lane2", 128'(lane_val(activations, 2)), 128'(11));
        en = 1'b1;
        @(negedge clk);
        check("s5_lane2_e3", 128'(lane_val(activations, 2)), 128'(12));
        @(negedge clk);
        @(negedge clk);
        check("s5_lane7_shift", 128'(lane_val(activations, 7)), 128'(29));
        start = 1'b0;
        load_valid = 1'b0;
        repeat (4) @(negedge clk);
        finish_done(5);
        run_scn1();
        finish_done(3);

        // Asynchronous reset mid-FEED.
        k_len = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s6_act", 128'(activations), 128'(0));
        check("s6_wgt", 128'(weights), 128'(0));
        check("s6_ld", 128'(lane_done), 128'(0));
        check("s6_busy", 128'(busy), 128'(0));
        check("s6_ready", 128'(load_ready), 128'(1));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("s6_no_done", 128'(done), 128'(0));
        load_scn1();
        run_scn1();
        finish_done(7);

        // Randomised passes against the model.
        for (int p = 0; p < 8; p++) begin
            kr = $urandom_range(1, D);
            for (int i = 0; i < L; i++)
                for (int j = 0; j < kr; j++)
                    load(i, j, $urandom, $urandom);
            for (int r = 0; r < 6; r++)
                load($urandom_range(0, L - 1), $urandom_range(0, kr - 1), $urandom, $urandom);
            k_len = KW'(kr);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            ended = 1'b0;
            for (int cyc = 0; cyc < 600 && !ended; cyc++) begin
                @(negedge clk);
                if (load_ready) begin
                    ended = 1'b1;
                end else begin
                    en = ($urandom_range(0, 9) != 0);
                    start = ($urandom_range(0, 7) == 0);
                    k_len = KW'($urandom_range(0, 31));
                    load_valid = ($urandom_range(0, 5) == 0);
                    load_lane = LW'($urandom);
                    load_idx = IW'($urandom);
                    load_act = DW'($urandom);
                    load_wgt = DW'($urandom);
                    array_done_in = (L'($urandom) & 8'h7F)
                                  | (($urandom_range(0, 24) == 0) ? 8'h80 : 8'h00);
                end
            end
            check("rnd_pass_end", 128'(ended), 128'(1));
            en = 1'b1;
            start = 1'b0;
            load_valid = 1'b0;
            array_done_in = '0;
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Parametrised RTL front-end for the NxN PE systolic cluster. It replaces the hand-skewed testbench stimulus with a synthesizable block.
- Stores per-lane activation and weight vectors in an internal buffer.
- On start, streams them into the array with a one-cycle-per-lane diagonal skew, zero bubbles, and per-lane done flags.
- Waits for the array's final done, or a timeout, then reports completion.

Parameters:
LANES, 8, number of array rows (skewed lanes)
DATA_W, 16, width of one activation/weight element
DEPTH, 16, max elements per lane held in buffer
TIMEOUT, 1024, max DRAIN cycles before an error completion
(derived) IDX_W = clog2(DEPTH), CNT_W = clog2(LANES+DEPTH+1), LEN_W = clog2(DEPTH+1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; low freezes all state and outputs
load_valid  in  1  write one buffer entry (IDLE only)
load_ready  out  1  high in IDLE; a write is accepted when load_valid && load_ready
load_lane  in  clog2(LANES)  target lane
load_idx  in  IDX_W  element index within lane
load_act  in  DATA_W  activation element
load_wgt  in  DATA_W  weight element
k_len  in  LEN_W  elements per lane, sampled at start
start  in  1  begin a feed pass
busy  out  1  pass in progress (FEED or DRAIN)
activations  out  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
weights  out  LANES*DATA_W  same packing
lane_done  out  LANES  per-lane done to array
array_done_in  in  LANES  output done vector from array
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse on rejected start or timeout

Behaviour:
- Reset (async): state=IDLE. Outputs: activations, weights, lane_done, busy, done and err all 0; load_ready=1. Buffer contents are undefined and need not be cleared. Reset mid-pass aborts immediately with no done pulse.
- en=0: every register holds, including counters, buffer and outputs. done/err pulses are extended while en=0. Loads and start are ignored.
- States: IDLE, FEED, DRAIN.
- IDLE:
  - Loads are accepted; when two writes hit the same entry, the last one wins.
  - start with 1<=k_len<=DEPTH: latch K=k_len, t=0, go to FEED.
  - start with k_len=0 or k_len>DEPTH: stay in IDLE, err pulse the next cycle.
- FEED (all outputs registered). Cycle 0 is the start edge. For lane i and counter t:
  - if i<=t<i+K: output buf[i][t-i] (act and wgt).
  - else: output 0.
  - when t==i+K: set lane_done[i]=1 (sticky).
  - So lane i element j is visible in cycle i+j+1, and lane_done[i] is first high in cycle i+K+1.
  - t increments each enabled cycle. Leave FEED after the cycle in which t==LANES-1+K, i.e. after lane_done[LANES-1] is set. Then go to DRAIN with the timeout counter at 0.
- DRAIN:
  - Outputs are 0; lane_done is held.
  - array_done_in[LANES-1]==1: done pulse, go to IDLE.
  - Counter reaches TIMEOUT-1 with no array done: done and err pulse together, go to IDLE.
  - array_done_in is ignored outside DRAIN.
- Entering IDLE clears lane_done and busy. busy=1 from cycle 1 through the last DRAIN cycle.
- start and loads while busy are ignored, and load_ready=0. A start in the same cycle as the DRAIN exit is ignored; the block re-arms in the next cycle.
- Arithmetic:
  - Data is passed unmodified with no sign handling.
  - Index t-i is computed in CNT_W bits and never underflows, because it is guarded by i<=t.
  - t saturates at LANES-1+K.

Decomposition:
- Shared package pe_pkg:
  - feeder state enum (IDLE/FEED/DRAIN)
  - defaults for LANES and DATA_W, shared with pe_8x8_cluster
  - a clog2 function
- One natural sub-module, skew_lane_buf: per-lane DEPTH-entry act/wgt register file with one write port and one async read port, instantiated LANES times via generate.
- The top holds the FSM, the t/timeout counters and the per-lane compare logic.

Test Plan:
1. Setup: LANES=8, K=4; load buf[i][j]=act 16'h(i*4+j+1), wgt 16'h(100+i*4+j); start at cycle 0.
   Required: lane0 shows 1,2,3,4 in cycles 1-4 and lane_done[0]=1 from cycle 5. Lane7 shows 29..32 in cycles 8-11 and lane_done[7]=1 from cycle 12. All other lane slots are 0.
2. Same pass; drive array_done_in[7]=1 twenty cycles after the DRAIN entry.
   Required: done pulses exactly one cycle later, busy falls in the same cycle, lane_done clears the cycle after.
3. array_done_in held 0, TIMEOUT=64.
   Required: done=err=1 for one cycle at DRAIN cycle 64, then return to IDLE.
4. start with k_len=0, then with k_len=17 (DEPTH=16).
   Required: an err pulse each time, busy stays 0, outputs stay 0.
5. Drop en for 3 cycles mid-FEED at t=5, and pulse start/load_valid during the pass.
   Required: outputs hold, the sequence resumes shifted by 3 cycles, and the stray start/loads have no effect on the buffer or the pass.
6. Assert rst_n=0 asynchronously at t=6 between clock edges.
   Required: all outputs go to 0 immediately and no done pulse is issued. A new pass after reset using freshly loaded data matches scenario 1.
